// File: rtl/layer_compositor_pkg.sv
// compositor_pkg: shared types and constants for layer_compositor.
//   state_e  - top-level sequencer states
//   L_MAX    - full-brightness level (identity scale)
//   L_W      - width of the brightness level register
//   chan_w() - bits per colour channel for a given pixel width
package compositor_pkg;

  typedef enum logic [1:0] {
    SPLASH   = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2,
    GAME     = 2'd3
  } state_e;

  localparam int L_MAX = 16;
  localparam int L_W   = 5;

  function automatic int chan_w(input int color_w);
    return color_w / 3;
  endfunction

endpackage

// File: rtl/layer_compositor_if.sv
// layer_compositor_if: pixel bus between the layer engines and the compositor.
//   video_on   - visible region, aligned with layer inputs
//   layer_on   - per-layer pixel valid
//   layer_mask - per-layer enable (1 = may win)
//   rgb_in     - packed layer colours, layer i at [i*COLOR_W +: COLOR_W]
//   rgb        - composited, scaled pixel (2-cycle latency)
//   hit_valid  - some layer won
//   hit_layer  - winning layer index
// master = pixel source side, slave = compositor side.
interface layer_compositor_if #(
  parameter int LAYERS  = 4,
  parameter int COLOR_W = 12,
  parameter int HL_W    = (LAYERS > 1) ? $clog2(LAYERS) : 1
);
  logic                      video_on;
  logic [LAYERS-1:0]         layer_on;
  logic [LAYERS-1:0]         layer_mask;
  logic [LAYERS*COLOR_W-1:0] rgb_in;
  logic [COLOR_W-1:0]        rgb;
  logic                      hit_valid;
  logic [HL_W-1:0]           hit_layer;

  modport master (
    output video_on, layer_on, layer_mask, rgb_in,
    input  rgb, hit_valid, hit_layer
  );

  modport slave (
    input  video_on, layer_on, layer_mask, rgb_in,
    output rgb, hit_valid, hit_layer
  );
endinterface

// File: rtl/layer_compositor_fade_scaler.sv
// fade_scaler: combinational brightness scale of a 3-channel pixel.
//   pix_i - input pixel, R in MSBs, C bits per channel
//   lvl_i - brightness level 0..16 (16 = identity, 0 = black)
//   pix_o - each channel = (ch * lvl) >> 4, truncated to C bits
module fade_scaler #(
  parameter int C = 4
) (
  input  logic [3*C-1:0] pix_i,
  input  logic [4:0]     lvl_i,
  output logic [3*C-1:0] pix_o
);

  for (genvar gc = 0; gc < 3; gc++) begin : g_ch
    logic [C+4:0] prod;
    logic         unused_bits;
    assign prod = {5'd0, pix_i[gc*C +: C]} * {{C{1'b0}}, lvl_i};
    assign pix_o[gc*C +: C] = prod[C+3:4];
    // Top bit is always 0 for lvl <= 16; low nibble is the shifted-out fraction.
    assign unused_bits = ^{prod[C+4], prod[3:0]};
  end

endmodule

// File: rtl/layer_compositor.sv
// layer_compositor: z-order merge of LAYERS pixel sources with a splash /
// fade-out / fade-in / game brightness sequencer.
//   clk, clr     - clock, asynchronous active-low reset
//   f_tick       - one-cycle end-of-frame pulse (fade stepping)
//   skip         - level, ends SPLASH early
//   px (slave)   - pixel bus: layer inputs in, rgb/hit_valid/hit_layer out
//   game_begin   - high from FADE_IN onward (registered from state)
//   fading       - high in FADE_OUT and FADE_IN (registered from state)
// Pipeline: stage 1 = priority select, stage 2 = brightness scale.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int LAYERS           = 4,
  parameter int COLOR_W          = 12,
  parameter int SPLASH_CYCLES    = 500_000_000,
  parameter int FADE_STEP_FRAMES = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                f_tick,
  input  logic                skip,
  layer_compositor_if.slave   px,
  output logic                game_begin,
  output logic                fading
);

  localparam int          C           = chan_w(COLOR_W);
  localparam int          HL_W        = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam logic [31:0] SPLASH_LAST = 32'(SPLASH_CYCLES - 1);
  localparam logic [7:0]  STEP_LAST   = 8'(FADE_STEP_FRAMES - 1);

  // ---------------- sequencer ----------------
  state_e           state_q, state_d;
  logic [31:0]      timer_q, timer_d;
  logic [7:0]       frame_q, frame_d;
  logic [L_W-1:0]   lvl_q, lvl_d;
  logic             game_begin_q, fading_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    frame_d = frame_q;
    lvl_d   = lvl_q;
    unique case (state_q)
      SPLASH: begin
        timer_d = timer_q + 32'd1;
        if (timer_q == SPLASH_LAST || skip) begin
          state_d = FADE_OUT;
          timer_d = '0;
          frame_d = '0;
        end
      end
      FADE_OUT: if (f_tick) begin
        if (frame_q == STEP_LAST) begin
          frame_d = '0;
          lvl_d   = lvl_q - 5'd1;
          if (lvl_q == 5'd1) state_d = FADE_IN;
        end else begin
          frame_d = frame_q + 8'd1;
        end
      end
      FADE_IN: if (f_tick) begin
        if (frame_q == STEP_LAST) begin
          frame_d = '0;
          lvl_d   = lvl_q + 5'd1;
          if (lvl_q == 5'(L_MAX - 1)) state_d = GAME;
        end else begin
          frame_d = frame_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= SPLASH;
      timer_q      <= '0;
      frame_q      <= '0;
      lvl_q        <= 5'(L_MAX);
      game_begin_q <= 1'b0;
      fading_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      frame_q      <= frame_d;
      lvl_q        <= lvl_d;
      // Status flags follow the state register, so they lag a transition by one cycle.
      game_begin_q <= (state_q == FADE_IN) || (state_q == GAME);
      fading_q     <= (state_q == FADE_OUT) || (state_q == FADE_IN);
    end
  end

  assign game_begin = game_begin_q;
  assign fading     = fading_q;

  // ---------------- stage 1: priority select ----------------
  // Chain walks upward, so the highest eligible index overwrites lower ones.
  logic [COLOR_W-1:0] ch_pix [LAYERS+1];
  logic [HL_W-1:0]    ch_idx [LAYERS+1];
  logic               ch_hit [LAYERS+1];

  assign ch_pix[0] = '0;
  assign ch_idx[0] = '0;
  assign ch_hit[0] = 1'b0;

  for (genvar gi = 0; gi < LAYERS; gi++) begin : g_lane
    logic elig;
    assign elig          = px.layer_on[gi] & px.layer_mask[gi];
    assign ch_pix[gi+1]  = elig ? px.rgb_in[gi*COLOR_W +: COLOR_W] : ch_pix[gi];
    assign ch_idx[gi+1]  = elig ? HL_W'(gi) : ch_idx[gi];
    assign ch_hit[gi+1]  = elig | ch_hit[gi];
  end

  logic win;
  assign win = ch_hit[LAYERS] & px.video_on;

  logic [COLOR_W-1:0] s1_pix_q;
  logic [HL_W-1:0]    s1_layer_q;
  logic [1:0]         vld_pipe_q;

  // ---------------- stage 2: brightness scale ----------------
  logic [COLOR_W-1:0] scaled;
  logic [COLOR_W-1:0] rgb_q;
  logic [HL_W-1:0]    hit_layer_q;

  fade_scaler #(.C(C)) u_scaler (
    .pix_i (s1_pix_q),
    .lvl_i (lvl_q),
    .pix_o (scaled)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1_pix_q    <= '0;
      s1_layer_q  <= '0;
      vld_pipe_q  <= '0;
      rgb_q       <= '0;
      hit_layer_q <= '0;
    end else begin
      s1_pix_q    <= win ? ch_pix[LAYERS] : '0;
      s1_layer_q  <= win ? ch_idx[LAYERS] : '0;
      vld_pipe_q  <= {vld_pipe_q[0], win};
      rgb_q       <= scaled;
      hit_layer_q <= s1_layer_q;
    end
  end

  assign px.rgb       = rgb_q;
  assign px.hit_valid = vld_pipe_q[1];
  assign px.hit_layer = hit_layer_q;

endmodule
